opal_serial_rx: RTL
===================

OPAL_SERIAL_RX -- requirements
Module: opal_serial_rx

Interface
REQ-001 Parameter NUM_CH, default 24: number of parallel serial data channels.
REQ-002 Parameter WORD_WIDTH, default 16: bits captured per channel per frame.
REQ-003 Parameter TIMEOUT_WIDTH, default 12: width of the timeout counter and its limit.
REQ-004 Parameter SYNC_STAGES, default 2, minimum 2: synchroniser depth for asynchronous inputs.
REQ-005 clk  input  1: system clock; all logic is clocked on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 i_clk  input  1: external serial bit clock, asynchronous to clk.
REQ-008 i_enable  input  1: frame enable, asynchronous.
REQ-009 i_data  input  NUM_CH: one serial bit per channel, asynchronous.
REQ-010 i_timeout  input  TIMEOUT_WIDTH: maximum clk cycles between serial edges; 0 disables the timeout.
REQ-011 o_data  output  NUM_CH*WORD_WIDTH: captured words; channel k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-012 o_valid  output  1: single-cycle pulse when o_data updates.
REQ-013 o_busy  output  1: high while a frame is in progress.
REQ-014 o_error  output  1: sticky; frame aborted by timeout or early enable drop.

Function
REQ-015 i_clk, i_enable and i_data each pass through SYNC_STAGES flops before use; all latencies count from the synchronised signals.
REQ-016 States: IDLE, WAIT_HIGH, WAIT_LOW, SHIFT, DONE, FAIL.
REQ-017 IDLE: enable=1 and i_clk=1 -> WAIT_LOW; enable=1 and i_clk=0 -> WAIT_HIGH; otherwise stay. On leaving IDLE: bit counter, shift registers and timeout counter cleared, o_error cleared.
REQ-018 WAIT_HIGH -> WAIT_LOW when i_clk=1; WAIT_LOW -> SHIFT when i_clk=0 (falling edge).
REQ-019 SHIFT (one cycle): every channel shifts in its synchronised i_data bit, MSB first; bit counter increments; counter reaching WORD_WIDTH -> DONE, else -> WAIT_HIGH.
REQ-020 Entry to DONE: o_data loads all shift registers and o_valid pulses for exactly one cycle; DONE -> IDLE when enable=0.
REQ-021 Timeout counter increments each cycle in WAIT_HIGH/WAIT_LOW and clears in SHIFT; with i_timeout nonzero and counter == i_timeout -> FAIL.
REQ-022 Enable=0 in WAIT_HIGH, WAIT_LOW or SHIFT -> FAIL; no o_valid, o_data unchanged.
REQ-023 FAIL (one cycle): sets o_error, -> IDLE.
REQ-024 o_busy = 1 in WAIT_HIGH, WAIT_LOW and SHIFT; 0 otherwise.
REQ-025 Timeout and enable drop in the same cycle: single FAIL entry, identical behaviour.
REQ-026 o_data holds its last valid frame indefinitely until the next DONE.

Reset
REQ-027 rst_n low: state=IDLE; o_data=0, o_valid=0, o_busy=0, o_error=0; all counters, shift registers and synchroniser flops zeroed.
REQ-028 Reset mid-frame discards the partial frame; no o_valid follows release.

Configuration
REQ-029 Macro OPAL_SERIAL_RX_PARITY_EN defined: each frame carries WORD_WIDTH+1 bits per channel, the last being even parity; output o_parity_err [NUM_CH-1:0] updates with o_valid, bit k set on channel k mismatch; parity bit excluded from o_data.
REQ-030 Macro undefined: WORD_WIDTH bits per frame; o_parity_err port and parity logic absent.

Structure
REQ-031 Package opal_pkg holds the state enum typedef and default values of NUM_CH, WORD_WIDTH and TIMEOUT_WIDTH.
REQ-032 Sub-module opal_sync implements the SYNC_STAGES synchroniser for a parametrised-width bus; it is instantiated once over {i_enable, i_clk, i_data}.

Verification
REQ-033 NUM_CH=2, WORD_WIDTH=16; ch0 sends 0xA5C3, ch1 sends 0x0001, i_clk period 8 clk -> one o_valid; o_data = 0x0001_A5C3; o_error=0.
REQ-034 Enable drops after 7 bits -> FAIL, o_error=1, no o_valid, o_data retains previous frame.
REQ-035 i_timeout=20, i_clk stalls high after bit 3 -> FAIL 20 cycles after the last edge; o_error=1; next good frame clears o_error and delivers its data.
REQ-036 i_timeout=0, i_clk stalls 5000 cycles then resumes -> frame completes correctly, o_error=0.
REQ-037 rst_n asserted after bit 10 and released -> all outputs 0; next full frame captured correctly.
REQ-038 PARITY_EN build: ch1 parity bit wrong -> o_parity_err = 2'b10 with o_valid, o_data correct.

Source files
------------

// File: rtl/opal_pkg.sv
// Shared types and default sizing for the opal serial receiver.
package opal_pkg;

    localparam int unsigned NumChDefault        = 24;
    localparam int unsigned WordWidthDefault    = 16;
    localparam int unsigned TimeoutWidthDefault = 12;

    typedef enum logic [2:0] {
        StIdle,
        StWaitHigh,
        StWaitLow,
        StShift,
        StDone,
        StFail
    } opal_state_e;

endpackage

// File: rtl/opal_sync.sv
// Multi-stage flop synchroniser for a bus of asynchronous level signals.
module opal_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/opal_serial_rx.sv
// Multi-channel serial frame receiver clocked by an external bit clock.
// Define OPAL_SERIAL_RX_PARITY_EN to add a trailing even-parity bit per channel.
module opal_serial_rx
    import opal_pkg::*;
#(
    parameter int unsigned NUM_CH        = NumChDefault,
    parameter int unsigned WORD_WIDTH    = WordWidthDefault,
    parameter int unsigned TIMEOUT_WIDTH = TimeoutWidthDefault,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clk,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_data,
    input  logic [TIMEOUT_WIDTH-1:0]     i_timeout,
    output logic [NUM_CH*WORD_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_error
`ifdef OPAL_SERIAL_RX_PARITY_EN
    ,
    output logic [NUM_CH-1:0]            o_parity_err
`endif
);

`ifdef OPAL_SERIAL_RX_PARITY_EN
    localparam int unsigned FrameBits = WORD_WIDTH + 1;
`else
    localparam int unsigned FrameBits = WORD_WIDTH;
`endif
    localparam int unsigned CntWidth = $clog2(FrameBits + 1);
    localparam int unsigned SyncW    = NUM_CH + 2;

    // Synchronised inputs
    logic [SyncW-1:0]  sync_out;
    logic              en_s;
    logic              sclk_s;
    logic [NUM_CH-1:0] data_s;

    opal_sync #(
        .WIDTH  (SyncW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({i_enable, i_clk, i_data}),
        .q_o   (sync_out)
    );

    assign en_s   = sync_out[NUM_CH+1];
    assign sclk_s = sync_out[NUM_CH];
    assign data_s = sync_out[NUM_CH-1:0];

    // State
    opal_state_e                  state_q, state_d;
    logic [CntWidth-1:0]          bit_cnt_q, bit_cnt_d;
    logic [TIMEOUT_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH*FrameBits-1:0]  shift_q, shift_d;
    logic [NUM_CH*WORD_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         error_q, error_d;

    logic [NUM_CH*FrameBits-1:0]  shift_next;
    logic [NUM_CH*WORD_WIDTH-1:0] frame_data;
    logic                         tmo_hit;
    logic                         last_bit;

`ifdef OPAL_SERIAL_RX_PARITY_EN
    logic [NUM_CH-1:0] perr_q, perr_d;
    logic [NUM_CH-1:0] frame_perr;
`endif

    // Shift-in of the current bit, MSB first; data word sits above any parity bit.
    always_comb begin
        shift_next = '0;
        frame_data = '0;
`ifdef OPAL_SERIAL_RX_PARITY_EN
        frame_perr = '0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            shift_next[k*FrameBits +: FrameBits] =
                {shift_q[k*FrameBits +: FrameBits-1], data_s[k]};
            frame_data[k*WORD_WIDTH +: WORD_WIDTH] =
                shift_next[k*FrameBits + (FrameBits - WORD_WIDTH) +: WORD_WIDTH];
`ifdef OPAL_SERIAL_RX_PARITY_EN
            frame_perr[k] = ^shift_next[k*FrameBits +: FrameBits];
`endif
        end
    end

    assign tmo_hit  = (i_timeout != '0) && (tmo_cnt_q == i_timeout);
    assign last_bit = (bit_cnt_q == CntWidth'(FrameBits - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = error_q;
`ifdef OPAL_SERIAL_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (en_s) begin
                    state_d   = sclk_s ? StWaitLow : StWaitHigh;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    shift_d   = '0;
                    error_d   = 1'b0;
                end
            end
            StWaitHigh: begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
                if (!en_s || tmo_hit) begin
                    state_d = StFail;
                end else if (sclk_s) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
                if (!en_s || tmo_hit) begin
                    state_d = StFail;
                end else if (!sclk_s) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                tmo_cnt_d = '0;
                if (!en_s) begin
                    state_d = StFail;
                end else begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + CntWidth'(1);
                    if (last_bit) begin
                        state_d = StDone;
                        data_d  = frame_data;
                        valid_d = 1'b1;
`ifdef OPAL_SERIAL_RX_PARITY_EN
                        perr_d  = frame_perr;
`endif
                    end else begin
                        state_d = StWaitHigh;
                    end
                end
            end
            StDone: begin
                if (!en_s) begin
                    state_d = StIdle;
                end
            end
            StFail: begin
                error_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

`ifdef OPAL_SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_parity_err = perr_q;
`endif

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_error = error_q;
    assign o_busy  = (state_q == StWaitHigh) || (state_q == StWaitLow) || (state_q == StShift);

endmodule
